ctrl_unit_mdu: RTL

Decode-stage control unit for the pipelined RV32 core, extended with the RV32M instructions and a sequencer for an iterative multiply/divide unit (MDU). It produces the same per-instruction control vector the ID stage already consumes. When an M-extension op is decoded, it launches the MDU, holds the front of the pipeline for a parametrised latency and issues a one-cycle MDU write-back. Latencies and M-support are parameters, so one block serves single-cycle-multiplier and iterative-divider builds.

---
 rtl/ctrl_unit_mdu.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_unit_mdu.sv
// ID-stage control unit for the RV32 pipeline: RV32I/RV32M decode plus the
// sequencer that launches the iterative MDU, holds the front end and issues write-back.
module ctrl_unit_mdu #(
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 33,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    input  logic        cmp_res,
    input  logic        flush,
    output logic        Branch,
    output logic        ALUSrc_A,
    output logic        ALUSrc_B,
    output logic        DatatoReg,
    output logic        RegWrite,
    output logic        mem_w,
    output logic        MIO,
    output logic        rs1use,
    output logic        rs2use,
    output logic        JALR,
    output logic [1:0]  hazard_optype,
    output logic [2:0]  ImmSel,
    output logic [2:0]  cmp_ctrl,
    output logic [3:0]  ALUControl,
    output logic        mdu_start,
    output logic [2:0]  mdu_op,
    output logic        mdu_wb,
    output logic        stall,
    output logic        illegal
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_PC4  = 4'd11;
    localparam logic [3:0] ALU_BOUT = 4'd12;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_inst_bits;

    assign opcode           = inst[6:0];
    assign funct3           = inst[14:12];
    assign funct7           = inst[31:25];
    assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_op = ALU_SLL;
            3'd2:    alu_op = ALU_SLT;
            3'd3:    alu_op = ALU_SLTU;
            3'd4:    alu_op = ALU_XOR;
            3'd5:    alu_op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    logic       dec_legal, dec_mop, dec_branch, dec_alusrc_a, dec_alusrc_b;
    logic       dec_datatoreg, dec_regwrite, dec_mem_w, dec_mio;
    logic       dec_rs1use, dec_rs2use, dec_jalr;
    logic [1:0] dec_hz;
    logic [2:0] dec_immsel, dec_cmp;
    logic [3:0] dec_alu;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec_legal     = 1'b0;
        dec_mop       = 1'b0;
        dec_branch    = 1'b0;
        dec_alusrc_a  = 1'b0;
        dec_alusrc_b  = 1'b0;
        dec_datatoreg = 1'b0;
        dec_regwrite  = 1'b0;
        dec_mem_w     = 1'b0;
        dec_mio       = 1'b0;
        dec_rs1use    = 1'b0;
        dec_rs2use    = 1'b0;
        dec_jalr      = 1'b0;
        dec_hz        = 2'd0;
        dec_immsel    = 3'd0;
        dec_cmp       = 3'd0;
        dec_alu       = 4'd0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'h01) begin
                    if (ENABLE_M) begin
                        dec_legal = 1'b1;
                        dec_mop   = 1'b1;
                        dec_hz    = 2'd1;
                    end
                end else if (funct7 == 7'h00 ||
                             (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
                    dec_legal    = 1'b1;
                    dec_regwrite = 1'b1;
                    dec_rs1use   = 1'b1;
                    dec_rs2use   = 1'b1;
                    dec_hz       = 2'd1;
                    dec_alu      = alu_op(funct3, funct7[5]);
                end
            end
            OP_I: begin
                // Only shift immediates constrain funct7; for the rest those bits are immediate.
                if ((funct3 != 3'd1 && funct3 != 3'd5) || funct7 == 7'h00 ||
                    (funct3 == 3'd5 && funct7 == 7'h20)) begin
                    dec_legal    = 1'b1;
                    dec_regwrite = 1'b1;
                    dec_rs1use   = 1'b1;
                    dec_alusrc_b = 1'b1;
                    dec_immsel   = 3'd1;
                    dec_hz       = 2'd1;
                    dec_alu      = alu_op(funct3, funct3 == 3'd5 && funct7[5]);
                end
            end
            OP_L: begin
                if (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7) begin
                    dec_legal     = 1'b1;
                    dec_regwrite  = 1'b1;
                    dec_datatoreg = 1'b1;
                    dec_mio       = 1'b1;
                    dec_rs1use    = 1'b1;
                    dec_alusrc_b  = 1'b1;
                    dec_immsel    = 3'd1;
                    dec_hz        = 2'd2;
                    dec_alu       = ALU_ADD;
                end
            end
            OP_S: begin
                if (funct3 <= 3'd2) begin
                    dec_legal    = 1'b1;
                    dec_mem_w    = 1'b1;
                    dec_mio      = 1'b1;
                    dec_rs1use   = 1'b1;
                    dec_rs2use   = 1'b1;
                    dec_alusrc_b = 1'b1;
                    dec_immsel   = 3'd4;
                    dec_hz       = 2'd3;
                    dec_alu      = ALU_ADD;
                end
            end
            OP_B: begin
                if (funct3 != 3'd2 && funct3 != 3'd3) begin
                    dec_legal  = 1'b1;
                    dec_branch = 1'b1;
                    dec_rs1use = 1'b1;
                    dec_rs2use = 1'b1;
                    dec_immsel = 3'd2;
                    dec_cmp    = funct3;
                end
            end
            OP_LUI: begin
                dec_legal    = 1'b1;
                dec_regwrite = 1'b1;
                dec_alusrc_b = 1'b1;
                dec_immsel   = 3'd5;
                dec_hz       = 2'd1;
                dec_alu      = ALU_BOUT;
            end
            OP_AUIPC: begin
                dec_legal    = 1'b1;
                dec_regwrite = 1'b1;
                dec_alusrc_a = 1'b1;
                dec_alusrc_b = 1'b1;
                dec_immsel   = 3'd5;
                dec_hz       = 2'd1;
                dec_alu      = ALU_ADD;
            end
            OP_JAL: begin
                dec_legal    = 1'b1;
                dec_branch   = 1'b1;
                dec_regwrite = 1'b1;
                dec_alusrc_a = 1'b1;
                dec_immsel   = 3'd3;
                dec_hz       = 2'd1;
                dec_alu      = ALU_PC4;
            end
            OP_JALR: begin
                if (funct3 == 3'd0) begin
                    dec_legal    = 1'b1;
                    dec_branch   = 1'b1;
                    dec_jalr     = 1'b1;
                    dec_regwrite = 1'b1;
                    dec_rs1use   = 1'b1;
                    dec_alusrc_a = 1'b1;
                    dec_immsel   = 3'd1;
                    dec_hz       = 2'd1;
                    dec_alu      = ALU_PC4;
                end
            end
            default: ;
        endcase
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_idle, launch_raw, busy_hold, in_done;

    assign is_idle    = (state_q == ST_IDLE);
    assign launch_raw = is_idle & inst_valid & dec_mop & ~flush;
    assign busy_hold  = (state_q == ST_BUSY) & ~flush;
    assign in_done    = (state_q == ST_DONE) & ~flush;

    // rst gates only the combinational launch path; the registers already clear asynchronously.
    assign mdu_start = launch_raw & ~rst;
    assign mdu_op    = mdu_start ? funct3 : 3'd0;
    assign stall     = mdu_start | busy_hold;
    assign mdu_wb    = in_done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_raw) begin
                    state_d = ST_BUSY;
                    cnt_d   = funct3[2] ? DIV_LOAD : MUL_LOAD;
                end
            end
            ST_BUSY: begin
                if (flush)               state_d = ST_IDLE;
                else if (cnt_q == '0)    state_d = ST_DONE;
                else                     cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // BUSY/DONE outputs come from the sequencer alone, independent of inst_valid.
    always_comb begin
        Branch        = 1'b0;
        ALUSrc_A      = 1'b0;
        ALUSrc_B      = 1'b0;
        DatatoReg     = 1'b0;
        RegWrite      = 1'b0;
        mem_w         = 1'b0;
        MIO           = 1'b0;
        rs1use        = 1'b0;
        rs2use        = 1'b0;
        JALR          = 1'b0;
        hazard_optype = 2'd0;
        ImmSel        = 3'd0;
        cmp_ctrl      = 3'd0;
        ALUControl    = 4'd0;
        illegal       = 1'b0;
        if (inst_valid) begin
            Branch        = dec_branch & cmp_res;
            ALUSrc_A      = dec_alusrc_a;
            ALUSrc_B      = dec_alusrc_b;
            DatatoReg     = dec_datatoreg;
            RegWrite      = dec_regwrite;
            mem_w         = dec_mem_w;
            MIO           = dec_mio;
            rs1use        = dec_mop ? is_idle : dec_rs1use;
            rs2use        = dec_mop ? is_idle : dec_rs2use;
            JALR          = dec_jalr;
            hazard_optype = dec_hz;
            ImmSel        = dec_immsel;
            cmp_ctrl      = dec_cmp;
            ALUControl    = dec_alu;
            illegal       = ~dec_legal;
        end
        if (in_done) RegWrite = 1'b1;
    end

endmodule
